mssd: RTL and testbench

Serial message demultiplexer with push-button bit clock. Each accepted clkPB press shifts one SerIn bit into a framing FSM. The FSM decodes a start bit, a 2-bit port address and a 4-bit length. It then routes the following payload bits to one of four output ports. Two seven-segment outputs show the selected port and the remaining payload count. It sits between board switches/buttons and LED/SSD outputs in the lab top level.

---
 rtl/mssd_pkg.sv | 26 ++
 rtl/mssd_one_pulser.sv | 29 ++
 rtl/mssd.sv | 97 +++++++++
 tb/tb_mssd.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mssd_pkg.sv
// Shared types and constants for the serial message demultiplexer.
// Holds the framing FSM state type and the hex-to-seven-segment table.
package mssd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        LEN  = 2'd2,
        DATA = 2'd3
    } state_t;

    localparam int ADDR_W = 2;
    localparam int CNT_W  = 4;
    localparam int PORTS  = 4;

    // Segment order is {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex7(input logic [3:0] v);
        return SEG_LUT[v];
    endfunction

endpackage

// File: rtl/mssd_one_pulser.sv
// Synchronizes the push-button bit clock and serial data into clk, and
// emits one bit_en per button press together with the aligned data bit.
module one_pulser (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    input  logic din,
    output logic bit_en,
    output logic bit_val
);

    logic [2:0] pb_sync;
    logic [1:0] din_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pb_sync  <= '0;
            din_sync <= '0;
        end else begin
            pb_sync  <= {pb_sync[1:0], pb};
            din_sync <= {din_sync[0], din};
        end
    end

    // Third stage only feeds edge detection, so a held button yields one pulse.
    assign bit_en  = pb_sync[1] & ~pb_sync[2];
    assign bit_val = din_sync[1];

endmodule

// File: rtl/mssd.sv
// Serial message demultiplexer: start bit, 2-bit port address, 4-bit length,
// then payload bits routed to one of four ports; SSDs show port and count.
module mssd
    import mssd_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       SerIn,
    input  logic       clkPB,
    output logic       done,
    output logic       SerOut_Valid,
    output logic [3:0] P,
    output logic [6:0] SSD_up,
    output logic [6:0] SSD_low
);

    logic              bit_en;
    logic              bit_val;
    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        idx;
    logic [CNT_W-1:0]  cnt_shift;

    one_pulser u_pulser (
        .clk     (clk),
        .rst     (rst),
        .pb      (clkPB),
        .din     (SerIn),
        .bit_en  (bit_en),
        .bit_val (bit_val)
    );

    assign cnt_shift = {cnt[CNT_W-2:0], bit_val};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            addr         <= '0;
            cnt          <= '0;
            idx          <= '0;
            done         <= 1'b0;
            SerOut_Valid <= 1'b0;
            P            <= '0;
        end else begin
            // Payload strobes last exactly one cycle.
            SerOut_Valid <= 1'b0;
            P            <= '0;
            if (bit_en) begin
                unique case (state)
                    IDLE: begin
                        if (bit_val) begin
                            state <= ADDR;
                            done  <= 1'b0;
                            idx   <= '0;
                        end
                    end
                    ADDR: begin
                        addr <= {addr[ADDR_W-2:0], bit_val};
                        idx  <= idx + 2'd1;
                        if (idx == 2'd1) begin
                            state <= LEN;
                            idx   <= '0;
                        end
                    end
                    LEN: begin
                        cnt <= cnt_shift;
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            idx <= '0;
                            if (cnt_shift == '0) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        P[addr]      <= bit_val;
                        SerOut_Valid <= 1'b1;
                        cnt          <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign SSD_up  = hex7({2'b00, addr});
    assign SSD_low = hex7(cnt);

endmodule

// File: tb/tb_mssd.sv
// Directed bench for mssd: button presses drive framed messages, a queue
// scoreboard checks every payload strobe, and display/flag state is checked.
module tb_mssd;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       SerIn = 1'b0;
    logic       clkPB = 1'b0;
    logic       done;
    logic       SerOut_Valid;
    logic [3:0] P;
    logic [6:0] SSD_up;
    logic [6:0] SSD_low;

    int total = 0;
    int bad = 0;
    int pulses = 0;
    int exp_pulses = 0;
    logic prev_valid = 1'b0;
    logic [3:0] sb_q[$];

    mssd dut (
        .clk          (clk),
        .rst          (rst),
        .SerIn        (SerIn),
        .clkPB        (clkPB),
        .done         (done),
        .SerOut_Valid (SerOut_Valid),
        .P            (P),
        .SSD_up       (SSD_up),
        .SSD_low      (SSD_low)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every strobe must match the oldest expected payload.
    always @(negedge clk) begin
        if (rst && SerOut_Valid) begin
            pulses++;
            total++;
            assert (!prev_valid) else begin
                bad++;
                $error("FAIL valid_width observed=2+ cycles expected=1 cycle");
            end
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $error("FAIL sb_unexpected observed=P=%h expected=no strobe", P);
            end else begin
                logic [3:0] e;
                e = sb_q.pop_front();
                assert (P === e) else begin
                    bad++;
                    $error("FAIL sb_payload observed=%h expected=%h", P, e);
                end
            end
        end else if (!SerOut_Valid) begin
            total++;
            assert (P === 4'h0) else begin
                bad++;
                $error("FAIL p_idle observed=%h expected=0", P);
            end
        end
        prev_valid = SerOut_Valid;
    end

    task automatic press(input logic b, input int hi = 6);
        @(negedge clk);
        SerIn = b;
        clkPB = 1'b1;
        repeat (hi) @(negedge clk);
        clkPB = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic data_bit(input logic b, input logic [1:0] a, input int hi = 6);
        logic [3:0] e;
        e = '0;
        e[a] = b;
        sb_q.push_back(e);
        exp_pulses++;
        press(b, hi);
    endtask

    initial begin
        // Presses during reset are lost.
        repeat (3) @(negedge clk);
        clkPB = 1'b1; SerIn = 1'b1;
        repeat (5) @(negedge clk);
        clkPB = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_done", {7'd0, done}, 8'h00);
        chk("rst_valid", {7'd0, SerOut_Valid}, 8'h00);
        chk("rst_p", {4'd0, P}, 8'h00);
        chk("rst_ssd_up", {1'b0, SSD_up}, 8'h3F);
        chk("rst_ssd_low", {1'b0, SSD_low}, 8'h3F);

        // Leading zeros while idle are ignored.
        press(0); press(0);
        chk("idle_zero_up", {1'b0, SSD_up}, 8'h3F);
        chk("idle_zero_low", {1'b0, SSD_low}, 8'h3F);

        // Message: addr=1, len=5, payload 0,1,0,1,0.
        press(1); press(0); press(1);
        chk("m1_ssd_up", {1'b0, SSD_up}, 8'h06);
        press(0); chk("m1_len0", {1'b0, SSD_low}, 8'h3F);
        press(1); chk("m1_len1", {1'b0, SSD_low}, 8'h06);
        press(0); chk("m1_len2", {1'b0, SSD_low}, 8'h5B);
        press(1); chk("m1_len3", {1'b0, SSD_low}, 8'h6D);
        chk("m1_done_pre", {7'd0, done}, 8'h00);
        data_bit(0, 2'd1); chk("m1_cnt4", {1'b0, SSD_low}, 8'h66);
        data_bit(1, 2'd1); chk("m1_cnt3", {1'b0, SSD_low}, 8'h4F);
        data_bit(0, 2'd1); chk("m1_cnt2", {1'b0, SSD_low}, 8'h5B);
        data_bit(1, 2'd1); chk("m1_cnt1", {1'b0, SSD_low}, 8'h06);
        chk("m1_done_mid", {7'd0, done}, 8'h00);
        data_bit(0, 2'd1); chk("m1_cnt0", {1'b0, SSD_low}, 8'h3F);
        chk("m1_done", {7'd0, done}, 8'h01);
        chk("m1_pulses", 8'(pulses), 8'(exp_pulses));

        // Zero-length message to port 3; start bit clears done first.
        press(0);
        chk("done_hold", {7'd0, done}, 8'h01);
        press(1);
        chk("start_clears_done", {7'd0, done}, 8'h00);
        press(1); press(1);
        press(0); press(0); press(0); press(0);
        chk("m2_ssd_up", {1'b0, SSD_up}, 8'h4F);
        chk("m2_done", {7'd0, done}, 8'h01);
        chk("m2_no_pulse", 8'(pulses), 8'(exp_pulses));

        // Long hold consumes exactly one bit: addr=2, len=3.
        press(1); press(1); press(0);
        press(0); press(0); press(1); press(1);
        chk("m3_ssd_up", {1'b0, SSD_up}, 8'h5B);
        chk("m3_len", {1'b0, SSD_low}, 8'h4F);
        data_bit(1, 2'd2, 20);
        chk("m3_hold_one_bit", {1'b0, SSD_low}, 8'h5B);
        chk("m3_hold_pulses", 8'(pulses), 8'(exp_pulses));

        // Reset in the middle of the payload aborts immediately.
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort_done", {7'd0, done}, 8'h00);
        chk("abort_valid", {7'd0, SerOut_Valid}, 8'h00);
        chk("abort_p", {4'd0, P}, 8'h00);
        chk("abort_ssd_up", {1'b0, SSD_up}, 8'h3F);
        chk("abort_ssd_low", {1'b0, SSD_low}, 8'h3F);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Fresh message after abort: addr=0, len=1, payload 1.
        press(1); press(0); press(0);
        press(0); press(0); press(0); press(1);
        chk("m4_ssd_low", {1'b0, SSD_low}, 8'h06);
        data_bit(1, 2'd0);
        chk("m4_done", {7'd0, done}, 8'h01);
        chk("m4_ssd_up", {1'b0, SSD_up}, 8'h3F);

        repeat (4) @(negedge clk);
        chk("final_pulses", 8'(pulses), 8'(exp_pulses));
        chk("final_sb_empty", 8'(sb_q.size()), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
